// File: rtl/key_request_arbiter.sv
// key_request_arbiter
// Shares one 256-bit private-key generator among NUM_REQ crypto cores.
// A single key is buffered from the generator and handed to one requester
// at a time in round-robin order. Once that key is consumed, the generator
// is advanced with a one-cycle gen_ready pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | waiting for gen_key_valid; the stall timer runs only here
// S_SETTLE | key captured; waiting for gen_key_valid to drop
// S_ARB    | key buffered; picking the next requester round-robin
// S_GRANT  | key presented to the granted requester until ack or withdraw
// S_ADV    | gen_ready high for one cycle to advance the generator
module key_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               key_clk,
  input  logic               key_reset,
  input  logic [255:0]       gen_key,
  input  logic               gen_key_valid,
  output logic               gen_ready,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [255:0]       key_out,
  output logic               key_out_valid,
  output logic [5:0]         key_count,
  output logic               key_wrap,
  output logic               err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_SETTLE,
    S_ARB,
    S_GRANT,
    S_ADV
  } state_t;

  state_t           state;
  logic [255:0]     key_buf;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] gnt_idx;
  logic [TMR_W-1:0] tmr;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;

  // Round-robin search starting just after the last consumer. The loop runs
  // from the farthest candidate to the nearest, so the nearest set request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Sequencer: key capture, grant/withdraw, generator advance, counters and flags.
  always_ff @(posedge key_clk) begin
    if (key_reset) begin
      state         <= S_WAIT;
      key_buf       <= '0;
      last          <= LAST_INIT;
      gnt_idx       <= '0;
      tmr           <= TMR_LOAD;
      gen_ready     <= 1'b0;
      gnt           <= '0;
      key_out       <= '0;
      key_out_valid <= 1'b0;
      key_count     <= '0;
      key_wrap      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (gen_key_valid) begin
            key_buf <= gen_key;
            tmr     <= TMR_LOAD;
            state   <= S_SETTLE;
          end else if (tmr == '0) begin
            // Stall flagged; keep waiting and let software decide on recovery.
            err_timeout <= 1'b1;
            tmr         <= TMR_LOAD;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        S_SETTLE: begin
          // The generator may hold valid for a second cycle; that cycle is not recaptured.
          if (!gen_key_valid) begin
            state <= S_ARB;
          end
        end

        S_ARB: begin
          if (pick_found) begin
            gnt           <= ONE_HOT0 << pick_idx;
            key_out       <= key_buf;
            key_out_valid <= 1'b1;
            gnt_idx       <= pick_idx;
            state         <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (ack[gnt_idx]) begin
            // ack wins over a simultaneous req drop: the key counts as consumed.
            gnt           <= '0;
            key_out       <= '0;
            key_out_valid <= 1'b0;
            last          <= gnt_idx;
            key_count     <= key_count + 6'd1;
            if (key_count == 6'd63) begin
              key_wrap <= 1'b1;
            end
            gen_ready     <= 1'b1;
            state         <= S_ADV;
          end else if (!req[gnt_idx]) begin
            // Withdrawn: keep the buffered key and pointer, arbitrate again.
            gnt           <= '0;
            key_out       <= '0;
            key_out_valid <= 1'b0;
            state         <= S_ARB;
          end
        end

        S_ADV: begin
          gen_ready <= 1'b0;
          state     <= S_WAIT;
        end

        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_request_arbiter.sv
// tb_key_request_arbiter
// Randomized scoreboard bench for key_request_arbiter with an attached
// generator model. Expected grants (index, key) are queued by the stimulus
// process and popped by a monitor process when a new grant appears.
module tb_key_request_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NKEYS          = 128;
  localparam int TARGET_KEYS    = 66;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic               key_clk = 1'b0;
  logic               key_reset;
  logic [255:0]       gen_key;
  logic               gen_key_valid;
  logic               gen_ready;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] gnt;
  logic [255:0]       key_out;
  logic               key_out_valid;
  logic [5:0]         key_count;
  logic               key_wrap;
  logic               err_timeout;

  always #5 key_clk = ~key_clk;

  key_request_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .key_clk(key_clk),
    .key_reset(key_reset),
    .gen_key(gen_key),
    .gen_key_valid(gen_key_valid),
    .gen_ready(gen_ready),
    .req(req),
    .ack(ack),
    .gnt(gnt),
    .key_out(key_out),
    .key_out_valid(key_out_valid),
    .key_count(key_count),
    .key_wrap(key_wrap),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int           idx;
    logic [255:0] key;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] keys[NKEYS];
  int           vectors      = 0;
  int           miscompares  = 0;
  int           grant_events = 0;
  int           ready_cycles = 0;
  bit           stall_next   = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference arbitration: first set request after lst, wrapping modulo NUM_REQ.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int lst);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (((r >> ((lst + k) % NUM_REQ)) & ONE) != '0) return (lst + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Generator model: emits key 0 after reset, then one key per ready high-then-low.
  // A held valid carries a corrupted key on its second cycle, so a recapture shows up.
  initial begin : gen_model
    int gi;
    gi            = 0;
    gen_key_valid = 1'b0;
    gen_key       = '0;
    @(negedge key_clk);
    while (key_reset) @(negedge key_clk);
    @(negedge key_clk);
    forever begin
      gen_key       = keys[gi % NKEYS];
      gen_key_valid = 1'b1;
      @(negedge key_clk);
      if ($urandom_range(0, 2) == 0) begin
        gen_key = ~keys[gi % NKEYS];
        @(negedge key_clk);
      end
      gen_key_valid = 1'b0;
      gen_key       = '0;
      gi++;
      while (!gen_ready) @(negedge key_clk);
      while (gen_ready) @(negedge key_clk);
      if (stall_next) begin
        stall_next = 1'b0;
        repeat (12) @(negedge key_clk);
        check("timeout_early", 256'(err_timeout), 256'(0));
        repeat (8) @(negedge key_clk);
        check("timeout_set", 256'(err_timeout), 256'(1));
        repeat (4) @(negedge key_clk);
      end else begin
        @(negedge key_clk);
      end
    end
  end

  // Monitor: per-cycle no-leak rule, gen_ready tally, and scoreboard pop on each new grant.
  initial begin : monitor
    logic [NUM_REQ-1:0] prev_gnt;
    exp_t e;
    prev_gnt = '0;
    forever begin
      @(negedge key_clk);
      if (gen_ready === 1'b1) ready_cycles++;
      if (gnt == '0) check("idle_no_leak", key_out | 256'(key_out_valid), 256'(0));
      else           check("valid_with_gnt", 256'(key_out_valid), 256'(1));
      if (gnt != '0 && gnt != prev_gnt) begin
        grant_events++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: gnt=%b with no grant expected", gnt);
        end else begin
          e = exp_q.pop_front();
          check("grant_index", 256'(gnt), 256'(ONE << e.idx));
          check("grant_key", key_out, e.key);
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic wait_grant(input int want_idx, output bit timed_out);
    int seen;
    int cnt;
    seen = grant_events;
    cnt  = 0;
    while (grant_events == seen && cnt < 100) begin
      @(negedge key_clk);
      cnt++;
    end
    vectors++;
    timed_out = (grant_events == seen);
    if (timed_out) begin
      miscompares++;
      $display("FAIL grant_timeout: no grant in 100 cycles, expected index %0d", want_idx);
    end
  endtask

  initial begin : stimulus
    int                 last_m;
    int                 consumed;
    int                 cur_idx;
    int                 iter;
    bit                 abort;
    bit                 do_drop;
    logic [NUM_REQ-1:0] nreq;

    for (int i = 0; i < NKEYS; i++) begin
      for (int w = 0; w < 8; w++) keys[i][w*32 +: 32] = $urandom;
    end

    key_reset = 1'b1;
    req       = '0;
    ack       = '0;
    repeat (3) @(negedge key_clk);
    check("rst_gnt", 256'(gnt), 256'(0));
    check("rst_key_out", key_out, 256'(0));
    check("rst_valid", 256'(key_out_valid), 256'(0));
    check("rst_gen_ready", 256'(gen_ready), 256'(0));
    check("rst_count", 256'(key_count), 256'(0));
    check("rst_wrap", 256'(key_wrap), 256'(0));
    check("rst_err", 256'(err_timeout), 256'(0));

    key_reset = 1'b0;
    req       = NUM_REQ'(1);
    last_m    = NUM_REQ - 1;
    consumed  = 0;
    cur_idx   = rr_pick(req, last_m);
    exp_q.push_back('{cur_idx, keys[0]});
    iter  = 0;
    abort = 1'b0;

    while (consumed < TARGET_KEYS && !abort && iter < 400) begin
      iter++;
      wait_grant(cur_idx, abort);
      if (abort) break;
      repeat ($urandom_range(0, 3)) @(negedge key_clk);

      if (NUM_REQ > 1 && $urandom_range(0, 3) == 0) begin
        ack = ONE << ((cur_idx + 1) % NUM_REQ);
        @(negedge key_clk);
        ack = '0;
        check("stray_ack_ignored", 256'(gnt), 256'(ONE << cur_idx));
      end

      do_drop = (NUM_REQ > 1) && (iter == 3 || (iter > 3 && $urandom_range(0, 5) == 0));
      if (do_drop) begin
        nreq = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
        nreq = nreq & ~(ONE << cur_idx);
        if (nreq == '0) nreq = ONE << ((cur_idx + 1) % NUM_REQ);
        req = nreq;
        @(negedge key_clk);
        check("withdraw_gnt", 256'(gnt), 256'(0));
        check("withdraw_count", 256'(key_count), 256'(consumed % 64));
        cur_idx = rr_pick(nreq, last_m);
        exp_q.push_back('{cur_idx, keys[consumed % NKEYS]});
        check("no_adv_on_drop", 256'(ready_cycles), 256'(consumed));
      end else begin
        ack = ONE << cur_idx;
        if ($urandom_range(0, 3) == 0) req = req & ~(ONE << cur_idx);
        @(negedge key_clk);
        ack      = '0;
        consumed = consumed + 1;
        last_m   = cur_idx;
        check("ack_gnt_clear", 256'(gnt), 256'(0));
        check("ack_key_count", 256'(key_count), 256'(consumed % 64));
        check("ack_key_wrap", 256'(key_wrap), 256'(consumed >= 64));
        check("adv_pulse_high", 256'(gen_ready), 256'(1));
        if (consumed == 5) stall_next = 1'b1;
        nreq    = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        req     = nreq;
        cur_idx = rr_pick(nreq, last_m);
        exp_q.push_back('{cur_idx, keys[consumed % NKEYS]});
        @(negedge key_clk);
        check("adv_pulse_low", 256'(gen_ready), 256'(0));
        check("adv_pulse_total", 256'(ready_cycles), 256'(consumed));
      end
    end

    if (!abort) begin
      check("keys_delivered", 256'(consumed), 256'(TARGET_KEYS));
      wait_grant(cur_idx, abort);
    end
    if (!abort) begin
      check("wrap_sticky", 256'(key_wrap), 256'(1));
      check("err_sticky", 256'(err_timeout), 256'(1));
      check("queue_drained", 256'(exp_q.size()), 256'(0));
      key_reset = 1'b1;
      @(negedge key_clk);
      check("mid_rst_gnt", 256'(gnt), 256'(0));
      check("mid_rst_key_out", key_out, 256'(0));
      check("mid_rst_valid", 256'(key_out_valid), 256'(0));
      check("mid_rst_wrap", 256'(key_wrap), 256'(0));
      check("mid_rst_count", 256'(key_count), 256'(0));
      check("mid_rst_err", 256'(err_timeout), 256'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_request_arbiter.md
Name: key_request_arbiter

Overview:
- Shares the single 256-bit private-key generator among NUM_REQ crypto cores (ECDH, ECDSA, etc.).
- Buffers one key from the generator and grants it round-robin to one requester at a time.
- Sequences the generator's ready/valid advance handshake.
- Counts delivered keys and flags key-table wrap and generator stalls.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
TIMEOUT_CYCLES, 16, max cycles to wait for gen_key_valid before err_timeout

Ports:
key_clk  in  1  system clock
key_reset  in  1  synchronous active-high reset
gen_key  in  256  key from generator
gen_key_valid  in  1  generator key strobe (may stay high up to 2 cycles)
gen_ready  out  1  advance strobe to generator (drives its top_ready)
req  in  NUM_REQ  per-requester key request, level
ack  in  NUM_REQ  per-requester consume strobe, 1 cycle
gnt  out  NUM_REQ  one-hot grant
key_out  out  256  buffered key, zero when gnt==0
key_out_valid  out  1  high while any gnt bit set
key_count  out  6  keys delivered mod 64
key_wrap  out  1  sticky: 64th key delivered (table reuse)
err_timeout  out  1  sticky: generator stall

Behaviour:
- One clock: key_clk. key_reset is synchronous and active-high. All outputs are registered.
- Reset state:
  - State S_WAIT.
  - gen_ready=0, gnt=0, key_out=0, key_out_valid=0, key_count=0, key_wrap=0, err_timeout=0.
  - Round-robin pointer last=NUM_REQ-1, so req[0] has first priority.
  - Key buffer cleared, timeout counter cleared.
- FSM:
  - S_WAIT: on the first cycle gen_key_valid=1, capture gen_key into the buffer and go to S_SETTLE. The generator emits key 0 automatically after its own reset, so no gen_ready is needed for the first key.
  - S_SETTLE: wait for gen_key_valid=0 (it may remain high one more cycle), then go to S_ARB. A second valid cycle must not re-capture.
  - S_ARB: if any req is set, pick the first set bit searching last+1, last+2, ... with modulo wrap. Next cycle: gnt one-hot, key_out=buffer, key_out_valid=1, go to S_GRANT. If req=0, stay in S_ARB holding the buffer.
  - S_GRANT:
    - ack at the granted index: next cycle gnt=0, key_out=0, key_out_valid=0; last updated to that index; key_count+1; go to S_ADV.
    - ack from a non-granted index is ignored.
    - Granted req drops without ack: withdraw grant and return to S_ARB. The key is retained, not consumed.
  - S_ADV: gen_ready=1 for exactly one cycle. Next cycle gen_ready=0 and go to S_WAIT.
  - The generator advances on the ready high-then-low sequence. The new gen_key_valid appears 2 cycles after gen_ready falls.
- Timeout: the counter runs only in S_WAIT.
  - On reaching TIMEOUT_CYCLES without valid, set err_timeout (sticky), reset the counter and keep waiting.
  - No automatic retry strobe.
- key_count wraps 63→0. key_wrap sets on that transition and is cleared only by reset.
- Simultaneous events:
  - ack and req drop in the same cycle: treated as ack (consumed).
  - New req arriving during S_GRANT/S_ADV/S_WAIT waits; no preemption.
- Reset mid-operation (any state): immediate return to reset state. The buffered key is discarded; the generator is expected to be reset together.
- key_out is never nonzero while gnt==0, so keys never leak to non-granted cores.
- Latency, idle to delivered: req asserted in S_ARB → gnt next cycle.
- Latency, ack to next key ready: ack → S_ADV (1) → S_WAIT → valid after +3 → S_SETTLE → S_ARB.

Test Plan:
- Reset then hold req=2'b01 with the generator model attached. Expect gnt=01 with key_out=256'hebcdf67a...859f. Ack → gen_ready single-cycle pulse, key_count=1. Next grant key_out=256'h68b66a7d...4e71.
- req=2'b11 continuously, acking each grant after 3 cycles. Expect gnt sequence 01,10,01,10. Keys 0,1,2,3 delivered in order, each exactly once.
- Granted requester 0 drops req before ack while req[1]=1. Expect gnt withdrawn, then gnt=10 with the same key 0, no gen_ready pulse, key_count unchanged.
- Generator holds gen_key_valid high 2 cycles. Expect exactly one capture, and key_count advances by exactly 1 per ack.
- Generator model stalled (no valid) for 20 cycles. Expect err_timeout=1 at cycle 16 of S_WAIT and sticky. A later valid is still captured and delivered normally.
- Deliver 64 keys. Expect key_count 63→0 and key_wrap=1. Assert key_reset while in S_GRANT: next cycle gnt=0, key_out=0, key_wrap=0, key_count=0.
